// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbitration of one SPI flash port across NUM_REQ masters.
// Optional SPI_ARB_TIMEOUT_EN adds a hold-time limit with forced revoke and lockout.
module spi_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int OWNER_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    input  logic [NUM_REQ-1:0] req_cs_b,
    input  logic [NUM_REQ-1:0] req_sck,
    input  logic [NUM_REQ-1:0] req_mosi,
    output logic               spi_cs_b,
    output logic               spi_sck,
    output logic               spi_mosi,
    output logic               busy,
    output logic [OWNER_W-1:0] owner,
    output logic               timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWNED = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || GUARD_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << 20)) begin : g_cfg_err
        $error("spi_bus_arbiter: parameter out of range");
    end

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] ptr_q, ptr_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic               cs_q, cs_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;

    logic [NUM_REQ-1:0] elig;
    logic               pick_vld;
    logic [OWNER_W-1:0] pick;
    logic               hi_vld;
    logic [OWNER_W-1:0] hi_pick;
    logic               lo_vld;
    logic [OWNER_W-1:0] lo_pick;
    logic               release_ok;
    logic [OWNER_W-1:0] ptr_next;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [19:0]        hold_q, hold_d;
    logic [NUM_REQ-1:0] lock_q, lock_d;
    logic               terr_q, terr_d;
    logic               expired;

    assign elig        = req & ~lock_q;
    assign expired     = (hold_q == 20'(TIMEOUT_CYCLES - 1));
    assign timeout_err = terr_q;
`else
    assign elig        = req;
    assign timeout_err = 1'b0;
`endif

    // First eligible bit at or above ptr, else first eligible bit overall (wrap).
    always_comb begin
        hi_vld  = 1'b0;
        hi_pick = '0;
        lo_vld  = 1'b0;
        lo_pick = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!hi_vld && elig[j] && (j >= int'(ptr_q))) begin
                hi_vld  = 1'b1;
                hi_pick = OWNER_W'(j);
            end
            if (!lo_vld && elig[j]) begin
                lo_vld  = 1'b1;
                lo_pick = OWNER_W'(j);
            end
        end
        pick_vld = hi_vld | lo_vld;
        pick     = hi_vld ? hi_pick : lo_pick;
    end

    assign release_ok = !req[owner_q] && req_cs_b[owner_q];
    assign ptr_next   = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0
                                                           : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gcnt_d  = gcnt_q;
        cs_d    = 1'b1;
        sck_d   = 1'b1;
        mosi_d  = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        hold_d  = hold_q;
        lock_d  = lock_q & req;
        terr_d  = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_OWNED;
                    gnt_d   = NUM_REQ'(1) << pick;
                    owner_d = pick;
`ifdef SPI_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            S_OWNED: begin
                if (release_ok) begin
                    state_d = S_GUARD;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    gcnt_d  = '0;
`ifdef SPI_ARB_TIMEOUT_EN
                end else if (expired) begin
                    state_d         = S_GUARD;
                    gnt_d           = '0;
                    ptr_d           = ptr_next;
                    gcnt_d          = '0;
                    terr_d          = 1'b1;
                    lock_d[owner_q] = 1'b1;
`endif
                end else begin
                    cs_d   = req_cs_b[owner_q];
                    sck_d  = req_sck[owner_q];
                    mosi_d = req_mosi[owner_q];
`ifdef SPI_ARB_TIMEOUT_EN
                    hold_d = hold_q + 20'd1;
`endif
                end
            end
            S_GUARD: begin
                if (gcnt_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            gcnt_q  <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gcnt_q  <= gcnt_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            lock_q <= '0;
            terr_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            lock_q <= lock_d;
            terr_q <= terr_d;
        end
    end
`endif

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign busy     = (state_q != S_IDLE);
    assign spi_cs_b = cs_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: vector table plus multi-cycle sequences.
// Timeout section follows SPI_ARB_TIMEOUT_EN, matching the RTL build.
module tb_spi_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] req_cs_b = 2'b11;
    logic [1:0] req_sck = 2'b11;
    logic [1:0] req_mosi = 2'b00;
    logic [1:0] gnt;
    logic       spi_cs_b, spi_sck, spi_mosi;
    logic       busy;
    logic       owner;
    logic       timeout_err;

    int nchk = 0;
    int nerr = 0;
    int hi_run = 0;

    spi_bus_arbiter #(
        .NUM_REQ(2),
        .GUARD_CYCLES(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .gnt(gnt),
        .req_cs_b(req_cs_b),
        .req_sck(req_sck),
        .req_mosi(req_mosi),
        .spi_cs_b(spi_cs_b),
        .spi_sck(spi_sck),
        .spi_mosi(spi_mosi),
        .busy(busy),
        .owner(owner),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] req;
        logic [1:0] cs;
        logic [1:0] sck;
        logic [1:0] mosi;
        logic [1:0] gnt;
        logic       pcs;
        logic       psck;
        logic       pmosi;
        logic       busy;
        logic       own;
    } vec_t;

    vec_t tbl[20];

    task automatic tick();
        @(posedge clk);
        #1;
        if (spi_cs_b) hi_run++;
        else hi_run = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req      = 2'b00;
        req_cs_b = 2'b11;
        req_sck  = 2'b11;
        req_mosi = 2'b00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] got;
        int         cnt, w, k, last_hi, terr_seen;

        // inputs {req, cs_b, sck, mosi} | expected {gnt, cs_b, sck, mosi, busy, owner}
        tbl[0]  = {2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = {2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = {2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = {2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = {2'b10, 2'b00, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = {2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = {2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = {2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = {2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = {2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = {2'b10, 2'b11, 2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = {2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[12] = {2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = {2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[14] = {2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[15] = {2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[16] = {2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[17] = {2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[18] = {2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[19] = {2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        idle_inputs();
        tick();
        chk("reset_state", {gnt, spi_cs_b, spi_sck, spi_mosi, busy, owner, timeout_err},
            {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tick();
        reset_n = 1'b1;

        // Vector table: grant, isolation, late cs, guard, round-robin pointer
        for (int i = 0; i < 20; i++) begin
            req      = tbl[i].req;
            req_cs_b = tbl[i].cs;
            req_sck  = tbl[i].sck;
            req_mosi = tbl[i].mosi;
            tick();
            chk($sformatf("vec%0d", i),
                {gnt, spi_cs_b, spi_sck, spi_mosi, busy, owner},
                {tbl[i].gnt, tbl[i].pcs, tbl[i].psck, tbl[i].pmosi,
                 tbl[i].busy, tbl[i].own});
        end

        // Reset in the middle of an owned transaction
        do_reset();
        req      = 2'b10;
        req_cs_b = 2'b01;
        req_sck  = 2'b00;
        tick();
        tick();
        chk("mid_owned", {gnt, spi_cs_b, busy, owner}, {2'b10, 1'b0, 1'b1, 1'b1});
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {gnt, spi_cs_b, spi_sck, busy, owner},
            {2'b00, 1'b1, 1'b1, 1'b0, 1'b0});
        tick();
        idle_inputs();
        tick();
        reset_n = 1'b1;

        // Single byte 0xA5, MSB first
        do_reset();
        req = 2'b01;
        chk("pre_grant", gnt, 2'b00);
        tick();
        chk("grant_lat", gnt, 2'b01);
        pat = 8'hA5;
        got = 8'h00;
        req_cs_b[0] = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            req_sck[0]  = 1'b0;
            req_mosi[0] = pat[b];
            tick();
            chk($sformatf("byte_lo%0d", b), {spi_cs_b, spi_sck, spi_mosi},
                {1'b0, 1'b0, pat[b]});
            req_sck[0] = 1'b1;
            tick();
            if (spi_sck) got = {got[6:0], spi_mosi};
        end
        chk("byte_val", got, 8'hA5);
        req         = 2'b00;
        req_cs_b[0] = 1'b1;
        req_mosi[0] = 1'b0;
        tick();
        chk("release", {gnt, busy}, {2'b00, 1'b1});
        cnt = 0;
        w   = 0;
        while (busy && w < 10) begin
            if (spi_cs_b) cnt++;
            tick();
            w++;
        end
        chk("guard_len", cnt, 4);
        chk("guard_idle", {busy, spi_cs_b}, {1'b0, 1'b1});

        // Round-robin with both requesting; owner re-requests right after release
        do_reset();
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            k = n % 2;
            w = 0;
            while (gnt == 2'b00 && w < 20) begin
                tick();
                w++;
            end
            chk($sformatf("rr_gnt%0d", n), gnt, 32'(1) << k);
            last_hi = hi_run;
            if (n > 0) chk($sformatf("rr_guard%0d", n), 32'(last_hi >= 4), 1);
            req_cs_b[k] = 1'b0;
            for (int b = 0; b < 8; b++) begin
                req_sck[k] = b[0];
                tick();
            end
            chk($sformatf("rr_cs%0d", n), spi_cs_b, 1'b0);
            req_cs_b[k] = 1'b1;
            req_sck[k]  = 1'b1;
            req[k]      = 1'b0;
            tick();
            req[k] = 1'b1;
        end

        // Owner drops req while cs_b is still low for 10 clocks
        do_reset();
        req = 2'b01;
        tick();
        req_cs_b[0] = 1'b0;
        tick();
        req = 2'b00;
        cnt = 0;
        repeat (10) begin
            tick();
            if (gnt == 2'b01) cnt++;
        end
        chk("late_hold", cnt, 10);
        req_cs_b[0] = 1'b1;
        tick();
        chk("late_rel", gnt, 2'b00);

`ifdef SPI_ARB_TIMEOUT_EN
        do_reset();
        req      = 2'b11;
        req_cs_b = 2'b10;
        tick();
        cnt = (gnt == 2'b01) ? 1 : 0;
        while (gnt == 2'b01 && cnt < 200) begin
            tick();
            if (gnt == 2'b01) cnt++;
        end
        chk("to_hold", cnt, 100);
        chk("to_pulse", {timeout_err, spi_cs_b, busy}, {1'b1, 1'b1, 1'b1});
        tick();
        chk("to_pulse_end", timeout_err, 1'b0);
        w = 0;
        while (gnt == 2'b00 && w < 20) begin
            tick();
            w++;
        end
        chk("to_next", gnt, 2'b10);
        req      = 2'b01;
        req_cs_b = 2'b11;
        tick();
        chk("to_rel1", gnt, 2'b00);
        cnt = 0;
        repeat (20) begin
            tick();
            if (gnt != 2'b00) cnt++;
        end
        chk("to_lockout", cnt, 0);
        req = 2'b00;
        tick();
        req = 2'b01;
        w   = 0;
        while (gnt == 2'b00 && w < 10) begin
            tick();
            w++;
        end
        chk("to_unlock", gnt, 2'b01);
`else
        do_reset();
        req      = 2'b01;
        req_cs_b = 2'b10;
        cnt       = 0;
        terr_seen = 0;
        tick();
        repeat (150) begin
            tick();
            if (gnt == 2'b01) cnt++;
            if (timeout_err) terr_seen++;
        end
        chk("no_to_hold", cnt, 150);
        chk("no_to_err", terr_seen, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
